// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// control-bundle layout and the canned control patterns driven per hazard.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned MEM_CNT_W   = 2;
    localparam int unsigned STALL_CNT_W = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_we;
        logic f2d_we;
        logic f2d_flush;
        logic d2e_we;
        logic d2e_bubble;
        logic e2m_we;
    } hz_ctrl_t;

    // Held while in reset: nothing advances and both pipeline registers load NOPs.
    localparam hz_ctrl_t CTRL_NOP = '{pc_we: 1'b0, f2d_we: 1'b0, f2d_flush: 1'b1,
                                      d2e_we: 1'b0, d2e_bubble: 1'b1, e2m_we: 1'b0};

    localparam hz_ctrl_t CTRL_RUN = '{pc_we: 1'b1, f2d_we: 1'b1, f2d_flush: 1'b0,
                                      d2e_we: 1'b1, d2e_bubble: 1'b0, e2m_we: 1'b1};

    localparam hz_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, f2d_we: 1'b0, f2d_flush: 1'b0,
                                         d2e_we: 1'b0, d2e_bubble: 1'b0, e2m_we: 1'b0};

    localparam hz_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, f2d_we: 1'b1, f2d_flush: 1'b1,
                                         d2e_we: 1'b1, d2e_bubble: 1'b1, e2m_we: 1'b1};

    localparam hz_ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, f2d_we: 1'b0, f2d_flush: 1'b0,
                                           d2e_we: 1'b1, d2e_bubble: 1'b1, e2m_we: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance-debug statistics; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush/freeze controller for the PC, F2D, D2E and E2M pipeline registers,
// covering load-use, taken-branch and multi-cycle memory hazards.
module hazard_control_unit #(
    parameter int unsigned REG_ADDR_W  = hazard_pkg::REG_ADDR_W,
    parameter int unsigned MEM_CNT_W   = hazard_pkg::MEM_CNT_W,
    parameter int unsigned STALL_CNT_W = hazard_pkg::STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  srcAAfterF2D,
    input  logic [REG_ADDR_W-1:0]  srcBAfterF2D,
    input  logic                   usesSrcA,
    input  logic                   usesSrcB,
    input  logic [REG_ADDR_W-1:0]  destAddrAfterD2E,
    input  logic                   RWAfterD2E,
    input  logic                   MTRAfterD2E,
    input  logic                   branchTaken,
    input  logic                   memMultiStart,
    input  logic [MEM_CNT_W-1:0]   memExtraCycles,
    output logic                   pcWriteEn,
    output logic                   f2dWriteEn,
    output logic                   f2dFlush,
    output logic                   d2eWriteEn,
    output logic                   d2eBubble,
    output logic                   e2mWriteEn,
    output logic [STALL_CNT_W-1:0] stallCount
);

    import hazard_pkg::*;

    hz_state_e            state_q, state_d;
    logic [MEM_CNT_W-1:0] wait_q, wait_d;
    hz_ctrl_t             ctrl_c;
    logic                 load_use_c;
    logic                 mem_start_c;

    assign load_use_c = MTRAfterD2E && RWAfterD2E &&
                        ((usesSrcA && (srcAAfterF2D == destAddrAfterD2E)) ||
                         (usesSrcB && (srcBAfterF2D == destAddrAfterD2E)));

    assign mem_start_c = memMultiStart && (memExtraCycles != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // wait_q counts the MEM_WAIT cycles still to come, so the whole freeze
    // (start cycle included) lasts exactly memExtraCycles cycles.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ctrl_c  = CTRL_RUN;
        case (state_q)
            RUN: begin
                if (mem_start_c) begin
                    ctrl_c  = CTRL_FREEZE;
                    wait_d  = memExtraCycles - MEM_CNT_W'(1);
                    state_d = (memExtraCycles == MEM_CNT_W'(1)) ? RUN : MEM_WAIT;
                end else if (branchTaken) begin
                    ctrl_c = CTRL_BRANCH;
                end else if (load_use_c) begin
                    ctrl_c = CTRL_LOAD_USE;
                end
            end
            MEM_WAIT: begin
                ctrl_c = CTRL_FREEZE;
                wait_d = wait_q - MEM_CNT_W'(1);
                if (wait_q <= MEM_CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
        endcase
        if (!rst) begin
            ctrl_c = CTRL_NOP;
        end
    end

    assign pcWriteEn  = ctrl_c.pc_we;
    assign f2dWriteEn = ctrl_c.f2d_we;
    assign f2dFlush   = ctrl_c.f2d_flush;
    assign d2eWriteEn = ctrl_c.d2e_we;
    assign d2eBubble  = ctrl_c.d2e_bubble;
    assign e2mWriteEn = ctrl_c.e2m_we;

    sat_counter #(
        .W (STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (~ctrl_c.pc_we),
        .count_o (stallCount)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized + directed bench for hazard_control_unit against a cycle-level
// behavioural model; a second instance with a 4-bit stall counter covers saturation.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] srcAAfterF2D, srcBAfterF2D, destAddrAfterD2E;
    logic       usesSrcA, usesSrcB, RWAfterD2E, MTRAfterD2E, branchTaken, memMultiStart;
    logic [1:0] memExtraCycles;

    logic        pcWriteEn, f2dWriteEn, f2dFlush, d2eWriteEn, d2eBubble, e2mWriteEn;
    logic [15:0] stallCount;
    logic        pc4, f2dwe4, flush4, d2ewe4, bubble4, e2mwe4;
    logic [3:0]  stallCount4;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining frozen cycles after the current one, and stall tallies.
    int freeze_left = 0;
    int stall16     = 0;
    int stall4      = 0;

    always #5 clk = ~clk;

    hazard_control_unit dut (
        .clk(clk), .rst(rst),
        .srcAAfterF2D(srcAAfterF2D), .srcBAfterF2D(srcBAfterF2D),
        .usesSrcA(usesSrcA), .usesSrcB(usesSrcB),
        .destAddrAfterD2E(destAddrAfterD2E), .RWAfterD2E(RWAfterD2E), .MTRAfterD2E(MTRAfterD2E),
        .branchTaken(branchTaken), .memMultiStart(memMultiStart), .memExtraCycles(memExtraCycles),
        .pcWriteEn(pcWriteEn), .f2dWriteEn(f2dWriteEn), .f2dFlush(f2dFlush),
        .d2eWriteEn(d2eWriteEn), .d2eBubble(d2eBubble), .e2mWriteEn(e2mWriteEn),
        .stallCount(stallCount)
    );

    hazard_control_unit #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .srcAAfterF2D(srcAAfterF2D), .srcBAfterF2D(srcBAfterF2D),
        .usesSrcA(usesSrcA), .usesSrcB(usesSrcB),
        .destAddrAfterD2E(destAddrAfterD2E), .RWAfterD2E(RWAfterD2E), .MTRAfterD2E(MTRAfterD2E),
        .branchTaken(branchTaken), .memMultiStart(memMultiStart), .memExtraCycles(memExtraCycles),
        .pcWriteEn(pc4), .f2dWriteEn(f2dwe4), .f2dFlush(flush4),
        .d2eWriteEn(d2ewe4), .d2eBubble(bubble4), .e2mWriteEn(e2mwe4),
        .stallCount(stallCount4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {pc, f2dWe, f2dFlush, d2eWe, d2eBubble, e2mWe} for the present cycle.
    function automatic logic [5:0] expect_ctrl();
        bit reads_pending_load;
        reads_pending_load = MTRAfterD2E && RWAfterD2E &&
            ((usesSrcA && srcAAfterF2D == destAddrAfterD2E) ||
             (usesSrcB && srcBAfterF2D == destAddrAfterD2E));
        if (!rst)                                     return 6'b001010;
        if (freeze_left > 0)                          return 6'b000000;
        if (memMultiStart && memExtraCycles != 2'd0)  return 6'b000000;
        if (branchTaken)                              return 6'b111111;
        if (reads_pending_load)                       return 6'b000111;
        return 6'b110101;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [5:0] e;
        if (!rst) begin
            freeze_left = 0;
            stall16     = 0;
            stall4      = 0;
        end else begin
            e = expect_ctrl();
            if (!e[5]) begin
                if (stall16 < 65535) stall16++;
                if (stall4 < 15)     stall4++;
            end
            if (freeze_left > 0)
                freeze_left--;
            else if (memMultiStart && memExtraCycles != 2'd0)
                freeze_left = int'(memExtraCycles) - 1;
        end
    end

    always @(negedge clk) begin
        logic [5:0] e;
        e = expect_ctrl();
        check("pcWriteEn",   32'(pcWriteEn),   32'(e[5]));
        check("f2dWriteEn",  32'(f2dWriteEn),  32'(e[4]));
        check("f2dFlush",    32'(f2dFlush),    32'(e[3]));
        check("d2eWriteEn",  32'(d2eWriteEn),  32'(e[2]));
        check("d2eBubble",   32'(d2eBubble),   32'(e[1]));
        check("e2mWriteEn",  32'(e2mWriteEn),  32'(e[0]));
        check("ctrl_w4",     32'({pc4, f2dwe4, flush4, d2ewe4, bubble4, e2mwe4}), 32'(e));
        check("stallCount",  32'(stallCount),  32'(stall16));
        check("stallCount4", 32'(stallCount4), 32'(stall4));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        srcAAfterF2D = 3'd0; srcBAfterF2D = 3'd0; destAddrAfterD2E = 3'd0;
        usesSrcA = 1'b0; usesSrcB = 1'b0; RWAfterD2E = 1'b0; MTRAfterD2E = 1'b0;
        branchTaken = 1'b0; memMultiStart = 1'b0; memExtraCycles = 2'd0;
    endtask

    task automatic set_load_use(input logic [2:0] src_a, input logic use_a, input logic rw);
        destAddrAfterD2E = 3'd3; MTRAfterD2E = 1'b1; RWAfterD2E = rw;
        srcAAfterF2D = src_a; usesSrcA = use_a;
    endtask

    initial begin
        clear_in();
        #1;
        check("rst_pc",     32'(pcWriteEn),  32'd0);
        check("rst_flush",  32'(f2dFlush),   32'd1);
        check("rst_bubble", 32'(d2eBubble),  32'd1);
        check("rst_e2m",    32'(e2mWriteEn), 32'd0);
        check("rst_count",  32'(stallCount), 32'd0);
        step(); step();
        rst = 1'b1;
        #1;
        check("run_pc",     32'(pcWriteEn), 32'd1);
        check("run_bubble", 32'(d2eBubble), 32'd0);

        // Load-use: one-cycle stall with a bubble into Execute.
        set_load_use(3'd3, 1'b1, 1'b1);
        #1;
        check("lu_pc",     32'(pcWriteEn),  32'd0);
        check("lu_f2dwe",  32'(f2dWriteEn), 32'd0);
        check("lu_bubble", 32'(d2eBubble),  32'd1);
        check("lu_e2m",    32'(e2mWriteEn), 32'd1);
        step();
        MTRAfterD2E = 1'b0;
        #1;
        check("lu_after_pc", 32'(pcWriteEn),  32'd1);
        check("lu_count",    32'(stallCount), 32'd1);

        // Near-misses must not stall.
        set_load_use(3'd3, 1'b0, 1'b1); #1;
        check("nf_nouse", 32'({pcWriteEn, d2eBubble}), 32'b10);
        step();
        set_load_use(3'd3, 1'b1, 1'b0); #1;
        check("nf_norw", 32'({pcWriteEn, d2eBubble}), 32'b10);
        step();
        set_load_use(3'd2, 1'b1, 1'b1); #1;
        check("nf_addr", 32'({pcWriteEn, d2eBubble}), 32'b10);
        step();

        // Branch squashes the Decode instruction, overriding load-use.
        set_load_use(3'd3, 1'b1, 1'b1);
        branchTaken = 1'b1;
        #1;
        check("br_flush", 32'({pcWriteEn, f2dFlush, d2eBubble}), 32'b111);
        step();
        clear_in();
        #1;
        check("br_count", 32'(stallCount), 32'd1);

        // Two-cycle memory freeze; a branch during the freeze waits for RUN.
        memMultiStart = 1'b1; memExtraCycles = 2'd2;
        #1;
        check("mm_start", 32'({pcWriteEn, f2dWriteEn, d2eWriteEn, e2mWriteEn, f2dFlush, d2eBubble}), 32'd0);
        step();
        memMultiStart = 1'b0; memExtraCycles = 2'd0; branchTaken = 1'b1;
        #1;
        check("mm_wait_pc",    32'(pcWriteEn), 32'd0);
        check("mm_wait_flush", 32'(f2dFlush),  32'd0);
        step();
        #1;
        check("mm_run_br", 32'({pcWriteEn, f2dFlush}), 32'b11);
        check("mm_count",  32'(stallCount), 32'd3);
        step();
        clear_in();

        // Asynchronous reset in the middle of a freeze.
        memMultiStart = 1'b1; memExtraCycles = 2'd3;
        step();
        memMultiStart = 1'b0; memExtraCycles = 2'd0;
        #1;
        rst = 1'b0;
        #1;
        check("ar_ctrl",  32'({pcWriteEn, f2dWriteEn, f2dFlush, d2eWriteEn, d2eBubble, e2mWriteEn}), 32'b001010);
        check("ar_count", 32'(stallCount), 32'd0);
        step(); step();
        rst = 1'b1;
        #1;
        check("ar_rel_pc", 32'(pcWriteEn), 32'd1);
        step();
        #1;
        check("ar_run_pc", 32'(pcWriteEn), 32'd1);

        // Held stall: narrow counter saturates, wide one keeps counting.
        set_load_use(3'd3, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) step();
        #1;
        check("sat_w4",  32'(stallCount4), 32'd15);
        check("sat_w16", 32'(stallCount),  32'd20);
        clear_in();

        for (int i = 0; i < 3000; i++) begin
            step();
            srcAAfterF2D     = 3'($urandom_range(0, 3));
            srcBAfterF2D     = 3'($urandom_range(0, 3));
            destAddrAfterD2E = 3'($urandom_range(0, 3));
            usesSrcA         = 1'($urandom_range(0, 1));
            usesSrcB         = 1'($urandom_range(0, 1));
            RWAfterD2E       = ($urandom_range(0, 3) != 0);
            MTRAfterD2E      = 1'($urandom_range(0, 1));
            branchTaken      = ($urandom_range(0, 5) == 0);
            memMultiStart    = ($urandom_range(0, 7) == 0);
            memExtraCycles   = 2'($urandom_range(0, 3));
            rst              = ($urandom_range(0, 199) != 0);
        end
        step();
        rst = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
